// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory arbiter and its round-robin picker.
// Optional bus-lock support elsewhere is enabled with the MEM_ARB_LOCK_EN macro.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_e;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 16;
  localparam int MAX_REQ    = 4;
  localparam int IDX_W      = $clog2(MAX_REQ);

  // Next round-robin start point after requester cur has been served.
  function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] cur, input int n);
    if (int'(cur) >= n - 1) begin
      return '0;
    end else begin
      return cur + IDX_W'(1);
    end
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-side signals of the shared data memory port.
// The slave modport is the arbiter; the master modport drives requests and memory read data.
interface mem_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        we;
  logic [NUM_REQ*ADDR_W-1:0] addr;
  logic [NUM_REQ*DATA_W-1:0] wdata;
  logic [NUM_REQ-1:0]        lock;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ-1:0]        ack;
  logic [DATA_W-1:0]         rd_data;
  logic [ADDR_W-1:0]         mem_addr;
  logic [DATA_W-1:0]         mem_wdata;
  logic                      mem_we;
  logic [DATA_W-1:0]         mem_rdata;

  modport slave (
    input  req, we, addr, wdata, lock, mem_rdata,
    output gnt, ack, rd_data, mem_addr, mem_wdata, mem_we
  );

  modport master (
    output req, we, addr, wdata, lock, mem_rdata,
    input  gnt, ack, rd_data, mem_addr, mem_wdata, mem_we
  );
endinterface

// File: rtl/mem_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping.
// Kept standalone so the IO-bus arbiter can reuse it.
module rr_picker
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               vld_o
);

  int   cand_s;
  logic found_s;

  // Rotating priority search starting at the round-robin pointer.
  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    found_s = 1'b0;
    cand_s  = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_s = (int'(ptr_i) + k) % NUM_REQ;
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!found_s && (j == cand_s) && req_i[j]) begin
          found_s  = 1'b1;
          gnt_o[j] = 1'b1;
          idx_o    = IDX_W'(j);
        end else begin
          found_s = found_s;
        end
      end
    end
    vld_o = found_s;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one synchronous single-port RAM between NUM_REQ requesters.
// Define MEM_ARB_LOCK_EN to let a requester hold the bus across accesses via its lock input.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W
) (
  input logic         clk,
  input logic         rst_n,
  mem_arbiter_if.slave bus_io
);

  arb_state_e         state_q;
  logic [IDX_W-1:0]   owner_q;
  logic [IDX_W-1:0]   rr_ptr_q;
  logic [NUM_REQ-1:0] gnt_q;
  logic [NUM_REQ-1:0] ack_q;
  logic [ADDR_W-1:0]  mem_addr_q;
  logic [DATA_W-1:0]  mem_wdata_q;
  logic               mem_we_q;

  logic [NUM_REQ-1:0] req_eff_s;
  logic [NUM_REQ-1:0] win_oh_s;
  logic [IDX_W-1:0]   win_idx_s;
  logic               win_vld_s;
  logic [ADDR_W-1:0]  sel_addr_s;
  logic [DATA_W-1:0]  sel_wdata_s;
  logic               sel_we_s;

`ifdef MEM_ARB_LOCK_EN
  logic [NUM_REQ-1:0] lock_oh_q;
  logic               lock_hold_s;

  // While the lock owner keeps lock high, only its request is visible to the picker.
  assign lock_hold_s = |(lock_oh_q & bus_io.lock);
  assign req_eff_s   = lock_hold_s ? (bus_io.req & lock_oh_q) : bus_io.req;
`else
  logic unused_lock;
  assign unused_lock = ^bus_io.lock;
  assign req_eff_s   = bus_io.req;
`endif

  rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req_i (req_eff_s),
    .ptr_i (rr_ptr_q),
    .gnt_o (win_oh_s),
    .idx_o (win_idx_s),
    .vld_o (win_vld_s)
  );

  // Route the winning requester's operands towards the memory port registers.
  always_comb begin
    sel_addr_s  = '0;
    sel_wdata_s = '0;
    sel_we_s    = 1'b0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (win_oh_s[j]) begin
        sel_addr_s  = bus_io.addr[j*ADDR_W +: ADDR_W];
        sel_wdata_s = bus_io.wdata[j*DATA_W +: DATA_W];
        sel_we_s    = bus_io.we[j];
      end else begin
        sel_we_s = sel_we_s;
      end
    end
  end

  // Arbitration FSM; memory port values are loaded on IDLE exit so they appear during ACCESS.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      gnt_q       <= '0;
      ack_q       <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
`ifdef MEM_ARB_LOCK_EN
      lock_oh_q   <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          ack_q <= '0;
`ifdef MEM_ARB_LOCK_EN
          if (!lock_hold_s) lock_oh_q <= '0;
`endif
          if (win_vld_s) begin
            owner_q     <= win_idx_s;
            gnt_q       <= win_oh_s;
            mem_addr_q  <= sel_addr_s;
            mem_wdata_q <= sel_wdata_s;
            mem_we_q    <= sel_we_s;
            state_q     <= ACCESS;
          end
        end
        ACCESS: begin
          mem_addr_q  <= '0;
          mem_wdata_q <= '0;
          mem_we_q    <= 1'b0;
          ack_q       <= gnt_q;
          state_q     <= RESP;
        end
        RESP: begin
          ack_q   <= '0;
          gnt_q   <= '0;
          state_q <= IDLE;
`ifdef MEM_ARB_LOCK_EN
          if (|(bus_io.lock & gnt_q)) lock_oh_q <= gnt_q;
          else                        rr_ptr_q  <= rr_next(owner_q, NUM_REQ);
`else
          rr_ptr_q <= rr_next(owner_q, NUM_REQ);
`endif
        end
        default: begin
          state_q     <= IDLE;
          gnt_q       <= '0;
          ack_q       <= '0;
          mem_addr_q  <= '0;
          mem_wdata_q <= '0;
          mem_we_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus_io.gnt       = gnt_q;
  assign bus_io.ack       = ack_q;
  assign bus_io.mem_addr  = mem_addr_q;
  assign bus_io.mem_wdata = mem_wdata_q;
  assign bus_io.mem_we    = mem_we_q;
  // The RAM output is already registered, so it is forwarded in the ack cycle.
  assign bus_io.rd_data   = (state_q == RESP) ? bus_io.mem_rdata : '0;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port synchronous data memory between NUM_REQ bus requesters, e.g. the bird CPU core plus a DMA/IO engine.
- Each requester has its own req/ack handshake. The arbiter picks a winner round-robin, drives the memory port for one cycle, then returns read data with a one-cycle ack pulse.
- Sits between the requesters' address/data_out/memld signals and the RAM.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- ADDR_W, 16, memory address width.
- DATA_W, 16, memory data width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  NUM_REQ  per-requester access request; held high with operands stable until ack.
- we  in  NUM_REQ  per-requester write enable (1 = store, 0 = load).
- addr  in  NUM_REQ*ADDR_W  packed request addresses; requester i at [i*ADDR_W +: ADDR_W].
- wdata  in  NUM_REQ*DATA_W  packed write data, same packing as addr.
- lock  in  NUM_REQ  per-requester bus-lock hint (used only with MEM_ARB_LOCK_EN).
- gnt  out  NUM_REQ  one-hot grant; high during ACCESS and RESP for the owner.
- ack  out  NUM_REQ  one-cycle completion pulse to the owner.
- rd_data  out  DATA_W  load data; valid only in the cycle ack is high.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_we  out  1  memory write strobe.
- mem_rdata  in  DATA_W  memory read data; registered, 1-cycle latency.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, gnt=0, ack=0, mem_we=0, mem_addr=0, mem_wdata=0, rd_data=0, rr_ptr=0, lock_owner invalid.
  - Reset during ACCESS drops mem_we immediately; that write may be lost and no ack is issued.
- FSM has three states: IDLE, ACCESS, RESP.
- IDLE:
  - If any req bit is set, pick a winner, register owner, set gnt[owner], go to ACCESS.
  - Otherwise stay in IDLE.
- ACCESS (1 cycle):
  - mem_addr = addr[owner], mem_wdata = wdata[owner], mem_we = we[owner].
  - Go to RESP.
- RESP (1 cycle):
  - ack[owner]=1, rd_data=mem_rdata. For a store, rd_data is don't-care but still driven from mem_rdata.
  - gnt cleared on exit; rr_ptr = (owner+1) mod NUM_REQ; go to IDLE.
- Latency and throughput:
  - req sampled high in IDLE at cycle 0 -> memory access in cycle 1 -> ack in cycle 2.
  - One access per 3 cycles maximum.
- Round-robin arbitration:
  - Search starts at rr_ptr and increases modulo NUM_REQ; the first set req bit wins.
  - A single requester is never starved while it holds req.
- Outside ACCESS: mem_we=0, mem_addr and mem_wdata hold 0.
- Protocol rules:
  - A requester drops req in the cycle after ack, or keeps it high for a back-to-back access.
  - A req that falls before ack is a protocol violation; the arbiter still completes the access.
  - Multiple simultaneous requests are resolved only in IDLE. Requests arriving during ACCESS or RESP wait.
- Invariants: gnt and ack are always one-hot or zero, and ack only occurs with gnt set.

Optional Feature:
- Macro MEM_ARB_LOCK_EN.
- Defined:
  - If lock[owner]=1 in RESP, owner becomes lock_owner.
  - In IDLE, while lock_owner is valid, only req[lock_owner] can win; other requests wait.
  - lock_owner is cleared in IDLE when lock[lock_owner]=0.
  - Used for atomic read-modify-write and CALL push/jump sequences.
  - rr_ptr is not advanced while locked.
- Not defined: the lock input is ignored and the lock_owner register is absent.

Decomposition:
- Package mem_arb_pkg:
  - State encoding (IDLE=2'd0, ACCESS=2'd1, RESP=2'd2).
  - Default ADDR_W/DATA_W constants.
  - MAX_REQ=4.
- Sub-module rr_picker: combinational, takes req vector and rr_ptr, returns one-hot winner and its index. Reusable for the IO-bus arbiter.

Test Plan:
- Single requester: req[0]=1, we=0, addr=16'h0010, mem holds 16'h1234 -> mem_addr=16'h0010 in cycle 1; ack[0] with rd_data=16'h1234 in cycle 2.
- Store: req[1]=1, we[1]=1, addr=16'h0020, wdata=16'hBEEF -> mem_we=1 for exactly one cycle with mem_addr=16'h0020; a later read returns 16'hBEEF.
- Contention: req=2'b11 held for 4 transactions after reset -> grant order 0,1,0,1, each ack 3 cycles apart.
- Reset during ACCESS of a store -> mem_we falls immediately; gnt=0, ack never pulses; after release, state=IDLE and rr_ptr=0.
- MEM_ARB_LOCK_EN: requester 0 holds lock=1 across two accesses while req[1]=1 -> both served to 0; requester 1 granted only after lock[0]=0.
- Idle bus: req=0 for 10 cycles -> gnt=0, ack=0, mem_we=0 throughout.
